i2s_audio_sequencer: RTL and testbench
======================================

// Module: i2s_audio_sequencer
// PURPOSE
//  Sequences the on-board I2S DAC and headphone amplifier: generates BCK/WS/DIN from
//  clk32, buffers one stereo sample from the core via valid/ready, and runs a pop-free
//  power sequence (amp enable delay, linear gain ramp up/down). Sits between the core's
//  16-bit stereo audio output and the hp_*/pa_en board pins.
// PARAMETERS
//  CLK_HZ     32000000  clk32 frequency in Hz
//  SAMPLE_HZ  24000     nominal frame rate; DIV=CLK_HZ/(SAMPLE_HZ*64), integer-truncated (default 20 -> 25000 Hz)
//  PA_DELAY   64        frames of silence after pa_en rises, before ramp-up starts (>=1)
// PORTS
//  clk32     in   1   system clock, all logic on rising edge
//  reset_n   in   1   synchronous active-low reset
//  enable    in   1   1 = audio requested, 0 = power down
//  mono      in   1   1 = both channels carry (L+R)>>>1
//  s_valid   in   1   sample pair valid
//  s_ready   out  1   holding register empty; transfer when s_valid&s_ready
//  s_left    in   16  signed two's-complement left sample
//  s_right   in   16  signed two's-complement right sample
//  hp_bck    out  1   I2S bit clock
//  hp_ws     out  1   I2S word select (0=left, 1=right)
//  hp_din    out  1   I2S serial data, MSB first
//  pa_en     out  1   amplifier enable
//  active    out  1   1 while state==RUN
//  underrun  out  1   1-cycle pulse: frame boundary in RUN with holding register empty
// BEHAVIOUR
//  Reset (reset_n=0 at clock edge): state OFF, gain=0, holding empty, all outputs 0 incl. s_ready.
//  Timing: divider c counts 0..DIV-1; at c==DIV-1 bck toggles. Slot counter s (0..31) advances
//   on the cycle bck goes 1->0; hp_din/hp_ws update that same cycle; DAC samples on bck rise.
//   Frame = 32 slots = 64*DIV clk32 cycles. Frame boundary = cycle s wraps 31->0.
//  Serialisation: hp_din = L'[15-s] for s 0..15, R'[31-s] for s 16..31; hp_ws=1 for s 15..30,
//   else 0 (WS leads MSB by one slot, standard I2S).
//  Frame latch at boundary: if holding full -> take it, mark empty; else reuse previous pair
//   (and pulse underrun if RUN). Mono: 17-bit sum L+R, >>>1, to both channels.
//   Gain g (9 bit, 0..256): X' = (X*g)>>>8, 25-bit signed product, truncate; g=256 is bit-exact.
//  Handshake: s_ready = !holding_full after reset. Accept in same cycle as s_valid&s_ready;
//   s_ready falls next cycle. Accept and boundary-latch in same cycle: boundary takes old
//   content, new pair written to holding (stays full). In OFF, accepted pairs are discarded.
//  FSM (transitions evaluated at frame boundaries except OFF exit):
//   OFF       bck/ws/din held 0, c=s=0, pa_en=0, g=0. enable=1 -> PA_WAIT next cycle.
//   PA_WAIT   pa_en=1, din forced 0; after PA_DELAY frames -> RAMP_UP; enable=0 -> OFF
//             (immediate, pa_en=0 next cycle, clocks stop).
//   RAMP_UP   g+=1 per frame; g reaches 256 -> RUN; enable=0 -> RAMP_DOWN from current g.
//   RUN       g=256, active=1; enable=0 -> RAMP_DOWN.
//   RAMP_DOWN g-=1 per frame; g==0 -> OFF; enable=1 -> RAMP_UP from current g.
//   g never wraps (saturates 0/256). enable glitches shorter than a frame are only seen if
//   present at a boundary (except in OFF/PA_WAIT).
//  Reset mid-frame: bits abort immediately, outputs 0 next edge; no partial-frame recovery.
// TESTING
//  1 reset_n=0 10 cycles, then 1, enable=0 -> all outputs 0 except s_ready=1; bck never toggles.
//  2 enable=1, DIV=20 -> pa_en=1 next cycle; bck period 40 cycles; din=0 for 64 frames;
//    active=1 after 64+256 frames.
//  3 RUN, feed L=16'h8001, R=16'h7FFE every frame -> DIN bitstream exact per slot map, WS
//    high slots 15..30; one-frame latency from accept to serialised MSB.
//  4 RUN, stop s_valid 3 frames -> underrun pulses 3x, last pair repeated 3 frames.
//  5 mono=1, L=16'h7FFF, R=16'h7FFF -> both channels 16'h7FFF; L=16'h8000,R=16'h7FFF -> 16'hFFFF.
//  6 RUN, drop enable, re-raise after 100 frames -> g 256->156 then rises to 256; pa_en stays
//    1; drop again until g=0 -> OFF, pa_en=0, bck stopped.

Source files
------------

// File: rtl/i2s_audio_sequencer.sv
// I2S DAC / headphone-amp sequencer: BCK/WS/DIN generation from clk32, a one-pair holding
// buffer, and pop-free amplifier power sequencing with a linear per-frame gain ramp.
module i2s_audio_sequencer #(
  parameter int CLK_HZ    = 32000000,
  parameter int SAMPLE_HZ = 24000,
  parameter int PA_DELAY  = 64
) (
  input  logic        clk32,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        mono,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_left,
  input  logic [15:0] s_right,
  output logic        hp_bck,
  output logic        hp_ws,
  output logic        hp_din,
  output logic        pa_en,
  output logic        active,
  output logic        underrun
);
  localparam int DIV = CLK_HZ / (SAMPLE_HZ * 64);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW  = (PA_DELAY > 1) ? $clog2(PA_DELAY) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [FW-1:0] F_LAST = FW'(PA_DELAY - 1);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_PA_WAIT   = 3'd1,
    ST_RAMP_UP   = 3'd2,
    ST_RUN       = 3'd3,
    ST_RAMP_DOWN = 3'd4
  } state_e;

  // Signed 16 x unsigned 9-bit gain, 25-bit product, arithmetic shift by 8, truncate to 16.
  function automatic logic [15:0] scale(input logic [15:0] x, input logic [8:0] g);
    logic signed [24:0] xe;
    logic signed [24:0] ge;
    logic signed [24:0] p;
    xe = 25'($signed(x));
    ge = 25'($signed({1'b0, g}));
    p  = xe * ge;
    return 16'(p >>> 8);
  endfunction

  function automatic logic [15:0] mono_avg(input logic [15:0] l, input logic [15:0] r);
    logic signed [16:0] sum;
    sum = 17'($signed(l)) + 17'($signed(r));
    return 16'(sum >>> 1);
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   c_q, c_d;
  logic [FW-1:0]   fc_q, fc_d;
  logic [4:0]      slot_q, slot_d;
  logic [8:0]      gain_q, gain_d;
  logic            bck_q, bck_d, ws_q, ws_d, din_q, din_d;
  logic            hold_full_q, hold_full_d;
  logic [15:0]     hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [15:0]     pair_l_q, pair_l_d, pair_r_q, pair_r_d;
  logic [15:0]     frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic            pa_en_q, pa_en_d, active_q, active_d, underrun_q, underrun_d;
  logic            s_ready_q, s_ready_d;
  logic            accept, running, tick, fall, boundary;
  logic [15:0]     src_l, src_r;
  logic [31:0]     frame_word;

  // Next-state, bit timing, frame latch and handshake logic.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    fc_d        = fc_q;
    slot_d      = slot_q;
    gain_d      = gain_q;
    bck_d       = bck_q;
    ws_d        = ws_q;
    din_d       = din_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    pair_l_d    = pair_l_q;
    pair_r_d    = pair_r_q;
    frame_l_d   = frame_l_q;
    frame_r_d   = frame_r_q;
    underrun_d  = 1'b0;

    accept   = s_valid & s_ready_q;
    running  = (state_q != ST_OFF) && !((state_q == ST_PA_WAIT) && !enable);
    tick     = (c_q == C_LAST);
    fall     = tick & bck_q;
    boundary = running & fall & (slot_q == 5'd31);

    if (mono) begin
      src_l = mono_avg(hold_l_q, hold_r_q);
      src_r = src_l;
    end else begin
      src_l = hold_l_q;
      src_r = hold_r_q;
    end

    case (state_q)
      ST_OFF: begin
        if (enable) state_d = ST_PA_WAIT;
        else        state_d = ST_OFF;
      end
      ST_PA_WAIT: begin
        if (!enable) begin
          state_d = ST_OFF;
          fc_d    = '0;
        end else if (boundary) begin
          if (fc_q == F_LAST) begin
            state_d = ST_RAMP_UP;
            fc_d    = '0;
          end else begin
            fc_d = fc_q + FW'(1);
          end
        end else begin
          fc_d = fc_q;
        end
      end
      ST_RAMP_UP: begin
        if (!boundary) begin
          state_d = ST_RAMP_UP;
        end else if (!enable) begin
          state_d = ST_RAMP_DOWN;
        end else if (gain_q >= 9'd255) begin
          gain_d  = 9'd256;
          state_d = ST_RUN;
        end else begin
          gain_d = gain_q + 9'd1;
        end
      end
      ST_RUN: begin
        if (boundary && !enable) state_d = ST_RAMP_DOWN;
        else                     state_d = ST_RUN;
      end
      ST_RAMP_DOWN: begin
        if (!boundary) begin
          state_d = ST_RAMP_DOWN;
        end else if (enable) begin
          state_d = ST_RAMP_UP;
        end else if (gain_q <= 9'd1) begin
          gain_d  = 9'd0;
          state_d = ST_OFF;
        end else begin
          gain_d = gain_q - 9'd1;
        end
      end
      default: state_d = ST_OFF;
    endcase

    // An accept coinciding with the boundary refills holding after the old content is taken.
    if (boundary) begin
      if (hold_full_q) begin
        pair_l_d    = src_l;
        pair_r_d    = src_r;
        hold_full_d = 1'b0;
      end else begin
        underrun_d = (state_q == ST_RUN);
      end
      frame_l_d = scale(pair_l_d, gain_d);
      frame_r_d = scale(pair_r_d, gain_d);
    end else begin
      frame_l_d = frame_l_q;
      frame_r_d = frame_r_q;
    end
    frame_word = {frame_l_d, frame_r_d};

    if ((state_q == ST_OFF) || (state_d == ST_OFF)) begin
      c_d         = '0;
      bck_d       = 1'b0;
      slot_d      = 5'd0;
      ws_d        = 1'b0;
      din_d       = 1'b0;
      hold_full_d = 1'b0;
    end else begin
      if (tick) begin
        c_d   = '0;
        bck_d = ~bck_q;
      end else begin
        c_d = c_q + CW'(1);
      end
      if (accept) begin
        hold_l_d    = s_left;
        hold_r_d    = s_right;
        hold_full_d = 1'b1;
      end else begin
        hold_l_d = hold_l_q;
      end
      if (fall) begin
        slot_d = slot_q + 5'd1;
        ws_d   = (slot_d >= 5'd15) && (slot_d <= 5'd30);
        din_d  = frame_word[5'd31 - slot_d] & (state_d != ST_PA_WAIT);
      end else begin
        slot_d = slot_q;
      end
    end

    s_ready_d = ~hold_full_d;
    pa_en_d   = (state_d != ST_OFF);
    active_d  = (state_d == ST_RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      state_q     <= ST_OFF;
      c_q         <= '0;
      fc_q        <= '0;
      slot_q      <= 5'd0;
      gain_q      <= 9'd0;
      bck_q       <= 1'b0;
      ws_q        <= 1'b0;
      din_q       <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= 16'd0;
      hold_r_q    <= 16'd0;
      pair_l_q    <= 16'd0;
      pair_r_q    <= 16'd0;
      frame_l_q   <= 16'd0;
      frame_r_q   <= 16'd0;
      pa_en_q     <= 1'b0;
      active_q    <= 1'b0;
      underrun_q  <= 1'b0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      fc_q        <= fc_d;
      slot_q      <= slot_d;
      gain_q      <= gain_d;
      bck_q       <= bck_d;
      ws_q        <= ws_d;
      din_q       <= din_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      pair_l_q    <= pair_l_d;
      pair_r_q    <= pair_r_d;
      frame_l_q   <= frame_l_d;
      frame_r_q   <= frame_r_d;
      pa_en_q     <= pa_en_d;
      active_q    <= active_d;
      underrun_q  <= underrun_d;
      s_ready_q   <= s_ready_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign hp_bck   = bck_q;
  assign hp_ws    = ws_q;
  assign hp_din   = din_q;
  assign pa_en    = pa_en_q;
  assign active   = active_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_i2s_audio_sequencer.sv
// Randomized bench for i2s_audio_sequencer: a frame-level behavioural model predicts every
// output each cycle; literal checks pin latencies, bitstreams and the model's arithmetic.
module tb_i2s_audio_sequencer;
  localparam int DIV      = 2;
  localparam int PA_DELAY = 4;
  localparam int FRAME    = 64 * DIV;
  localparam int M_OFF = 0, M_PAW = 1, M_UP = 2, M_RUN = 3, M_DOWN = 4;

  logic clk32 = 1'b0;
  logic reset_n, enable, mono, s_valid;
  logic [15:0] s_left, s_right;
  logic s_ready, hp_bck, hp_ws, hp_din, pa_en, active, underrun;

  i2s_audio_sequencer #(.CLK_HZ(32000000), .SAMPLE_HZ(250000), .PA_DELAY(PA_DELAY)) dut (
    .clk32(clk32), .reset_n(reset_n), .enable(enable), .mono(mono),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .hp_bck(hp_bck), .hp_ws(hp_ws), .hp_din(hp_din), .pa_en(pa_en),
    .active(active), .underrun(underrun)
  );

  always #5 clk32 = ~clk32;

  int checks = 0, failures = 0;
  int cyc = 0;
  int feed = 0;
  logic [15:0] fix_l = 16'd0, fix_r = 16'd0;

  // behavioural model state
  int m_mode = M_OFF, n = 0, g = 0, fc = 0, pair_l = 0, pair_r = 0, e_slot = 0;
  logic [31:0] hold_q[$];
  logic [15:0] cur_l = 16'd0, cur_r = 16'd0;
  logic e_bck = 1'b0, e_ws = 1'b0, e_din = 1'b0, e_pa = 1'b0, e_act = 1'b0, e_und = 1'b0, e_rdy = 1'b0;
  logic m_acc = 1'b0, m_bnd = 1'b0, prev_bck = 1'b0;
  logic [31:0] cap_d = 32'd0, cap_w = 32'd0, last_frame = 32'd0, last_ws = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [15:0] m_scale(input int x, input int gg);
    int v;
    v = fdiv(x * gg, 256);
    return v[15:0];
  endfunction

  function automatic logic [15:0] m_avg(input int l, input int r);
    int v;
    v = fdiv(l + r, 2);
    return v[15:0];
  endfunction

  task automatic model_step();
    logic [31:0] h;
    int l, r;
    m_acc = s_valid && e_rdy;
    m_bnd = 1'b0;
    e_und = 1'b0;
    cyc++;
    if (!reset_n) begin
      m_mode = M_OFF; n = 0; g = 0; fc = 0; pair_l = 0; pair_r = 0;
      cur_l = 16'd0; cur_r = 16'd0; hold_q.delete();
    end else if (m_mode == M_OFF) begin
      hold_q.delete();
      if (enable) begin m_mode = M_PAW; n = 0; fc = 0; end
    end else if (m_mode == M_PAW && !enable) begin
      m_mode = M_OFF;
      hold_q.delete();
    end else begin
      n++;
      if (n % FRAME == 0) begin
        m_bnd = 1'b1;
        if (hold_q.size() > 0) begin
          h = hold_q.pop_front();
          l = int'($signed(h[31:16]));
          r = int'($signed(h[15:0]));
          if (mono) begin l = fdiv(l + r, 2); r = l; end
          pair_l = l; pair_r = r;
        end else if (m_mode == M_RUN) begin
          e_und = 1'b1;
        end
        case (m_mode)
          M_PAW:  begin fc++; if (fc == PA_DELAY) m_mode = M_UP; end
          M_UP:   if (!enable) m_mode = M_DOWN;
                  else begin g = (g + 1 > 256) ? 256 : g + 1; if (g == 256) m_mode = M_RUN; end
          M_RUN:  if (!enable) m_mode = M_DOWN;
          M_DOWN: if (enable) m_mode = M_UP;
                  else begin g = (g - 1 < 0) ? 0 : g - 1; if (g == 0) m_mode = M_OFF; end
          default: m_mode = M_OFF;
        endcase
        cur_l = m_scale(pair_l, g);
        cur_r = m_scale(pair_r, g);
      end
      if (m_mode == M_OFF) hold_q.delete();
      else if (m_acc) hold_q.push_back({s_left, s_right});
    end
    e_rdy = reset_n && (hold_q.size() == 0);
    if (m_mode == M_OFF) begin
      e_bck = 1'b0; e_ws = 1'b0; e_din = 1'b0; e_slot = 0;
    end else begin
      e_bck  = ((n / DIV) % 2) == 1;
      e_slot = (n / (2 * DIV)) % 32;
      e_ws   = (e_slot >= 15) && (e_slot <= 30);
      if (m_mode == M_PAW) e_din = 1'b0;
      else if (e_slot < 16) e_din = cur_l[15 - e_slot];
      else e_din = cur_r[31 - e_slot];
    end
    e_pa  = (m_mode != M_OFF);
    e_act = (m_mode == M_RUN);
  endtask

  // Per-cycle compare against the model, plus per-frame bit capture on BCK rise.
  initial begin
    forever begin
      @(posedge clk32);
      model_step();
      #1;
      chk("s_ready", s_ready, e_rdy);
      chk("hp_bck", hp_bck, e_bck);
      chk("hp_ws", hp_ws, e_ws);
      chk("hp_din", hp_din, e_din);
      chk("pa_en", pa_en, e_pa);
      chk("active", active, e_act);
      chk("underrun", underrun, e_und);
      if (hp_bck && !prev_bck) begin
        cap_d[31 - e_slot] = hp_din;
        cap_w[31 - e_slot] = hp_ws;
      end
      prev_bck = hp_bck;
      if (m_bnd) begin last_frame = cap_d; last_ws = cap_w; end
    end
  end

  // Source driver: 0 idle, 1 random pairs with random valid, 2 fixed pair always valid.
  initial begin
    forever begin
      @(negedge clk32);
      case (feed)
        1: begin
          if (m_acc || !s_valid) begin s_left = 16'($urandom); s_right = 16'($urandom); end
          s_valid = ($urandom_range(0, 3) != 0);
        end
        2: begin s_valid = 1'b1; s_left = fix_l; s_right = fix_r; end
        default: s_valid = 1'b0;
      endcase
    end
  end

  initial begin
    int cnt, t0, ucnt;
    reset_n = 1'b0; enable = 1'b0; mono = 1'b0;
    s_valid = 1'b0; s_left = 16'd0; s_right = 16'd0;

    chk("pin_scale_full", {16'd0, m_scale(-32767, 256)}, 32'h0000_8001);
    chk("pin_scale_half", {16'd0, m_scale(32767, 128)}, 32'h0000_3FFF);
    chk("pin_scale_neg", {16'd0, m_scale(-1, 1)}, 32'h0000_FFFF);
    chk("pin_mono_avg", {16'd0, m_avg(-32768, 32767)}, 32'h0000_FFFF);

    repeat (10) @(negedge clk32);
    chk("reset_ready", s_ready, 1'b0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk32);
    chk("idle_ready", s_ready, 1'b1);
    chk("idle_pa_en", pa_en, 1'b0);

    // power-up
    feed = 1; enable = 1'b1;
    @(negedge clk32);
    chk("pa_en_next_cycle", pa_en, 1'b1);
    t0 = cyc;
    cnt = 0;
    while (!hp_bck && cnt < 100) begin @(negedge clk32); cnt++; end
    cnt = 0;
    while (hp_bck && cnt < 100) begin @(negedge clk32); cnt++; end
    while (!hp_bck && cnt < 100) begin @(negedge clk32); cnt++; end
    chk("bck_period", cnt, 2 * DIV);
    while (!active && (cyc - t0) < 40000) @(negedge clk32);
    chk("active_latency", cyc - t0, (PA_DELAY + 256) * FRAME);

    // fixed stereo bitstream
    feed = 2; fix_l = 16'h8001; fix_r = 16'h7FFE;
    repeat (4 * FRAME) @(negedge clk32);
    chk("frame_bits", last_frame, 32'h8001_7FFE);
    chk("frame_ws", last_ws, 32'h0001_FFFE);

    // underrun: stop feeding mid-frame with holding full
    cnt = 0;
    while (!m_bnd && cnt < 2 * FRAME) begin @(negedge clk32); cnt++; end
    repeat (FRAME / 2) @(negedge clk32);
    feed = 0; ucnt = 0;
    repeat (4 * FRAME) begin @(negedge clk32); ucnt += int'(underrun); end
    chk("underrun_count", ucnt, 3);
    chk("repeat_pair", last_frame, 32'h8001_7FFE);

    // mono
    mono = 1'b1; fix_l = 16'h7FFF; fix_r = 16'h7FFF; feed = 2;
    repeat (4 * FRAME) @(negedge clk32);
    chk("mono_pos", last_frame, 32'h7FFF_7FFF);
    fix_l = 16'h8000;
    repeat (4 * FRAME) @(negedge clk32);
    chk("mono_mixed", last_frame, 32'hFFFF_FFFF);
    mono = 1'b0;

    // ramp down, re-raise, then full power-down
    feed = 1; enable = 1'b0;
    repeat (20 * FRAME) @(negedge clk32);
    chk("pa_en_during_ramp", pa_en, 1'b1);
    enable = 1'b1;
    t0 = cyc;
    while (!active && (cyc - t0) < 20000) @(negedge clk32);
    chk("reactive", active, 1'b1);
    enable = 1'b0;
    t0 = cyc;
    while (pa_en && (cyc - t0) < 40000) @(negedge clk32);
    chk("off_latency", ((cyc - t0) > 256 * FRAME) && ((cyc - t0) <= 257 * FRAME), 1'b1);
    repeat (50) @(negedge clk32);
    chk("off_bck", hp_bck, 1'b0);

    // reset mid-frame while clocks run
    enable = 1'b1;
    repeat (700) @(negedge clk32);
    reset_n = 1'b0;
    repeat (3) @(negedge clk32);
    chk("midreset_pa_en", pa_en, 1'b0);
    chk("midreset_bck", hp_bck, 1'b0);
    enable = 1'b0; reset_n = 1'b1;
    repeat (20) @(negedge clk32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
